// File: rtl/uart_rx_deser.sv
// UART receive deserializer: mid-bit sampling of a synchronized rx line,
// LSB-first reassembly with optional parity, one-cycle valid strobe plus flags.
module uart_rx_deser #(
  parameter int DATA_W     = 8,
  parameter int BAUD_DIV   = 434,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              parity_err_o,
  output logic              frame_err_o,
  output logic              busy_o
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam int IDX_W = $clog2(DATA_W);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(BAUD_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
  localparam logic             ODD_L    = (PARITY_ODD != 0);
  localparam logic             PAR_L    = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Error flag: data XOR parity bit must equal the configured sense.
  function automatic logic parity_err_f(input logic [DATA_W-1:0] d, input logic p);
    return ((^d) ^ p) != ODD_L;
  endfunction

  state_t              state_r, state_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic [IDX_W-1:0]    idx_r, idx_s;
  logic [DATA_W-1:0]   shift_r, shift_s;
  logic                par_r, par_s;
  logic                stop_r, stop_s;
  logic                done_r, done_s;

  logic [DATA_W-1:0]   data_r;
  logic                valid_r;
  logic                perr_r;
  logic                ferr_r;
  logic                busy_r;

  // Next-state and datapath update for the receive FSM.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    idx_s   = idx_r;
    shift_s = shift_r;
    par_s   = par_r;
    stop_s  = stop_r;
    done_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (rx_i == 1'b0) begin
          state_s = S_START;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_START: begin
        if (cnt_r == HALF_M1) begin
          cnt_s = CNT_ZERO;
          idx_s = IDX_ZERO;
          // A start bit that is already high again at mid-bit was a glitch.
          if (rx_i == 1'b0) begin
            state_s = S_DATA;
          end else begin
            state_s = S_IDLE;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      S_DATA: begin
        if (cnt_r == FULL_M1) begin
          cnt_s   = CNT_ZERO;
          shift_s = {rx_i, shift_r[DATA_W-1:1]};
          if (idx_r == IDX_LAST) begin
            idx_s   = IDX_ZERO;
            state_s = PAR_L ? S_PARITY : S_STOP;
          end else begin
            idx_s = idx_r + IDX_ONE;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      S_PARITY: begin
        if (cnt_r == FULL_M1) begin
          cnt_s   = CNT_ZERO;
          par_s   = rx_i;
          state_s = S_STOP;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      S_STOP: begin
        // Return to IDLE at mid-stop so a following start edge is not missed.
        if (cnt_r == FULL_M1) begin
          cnt_s   = CNT_ZERO;
          stop_s  = rx_i;
          done_s  = 1'b1;
          state_s = S_IDLE;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = S_IDLE;
        cnt_s   = CNT_ZERO;
        idx_s   = IDX_ZERO;
      end
    endcase
  end

  // FSM state, counters and capture registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      cnt_r   <= CNT_ZERO;
      idx_r   <= IDX_ZERO;
      shift_r <= {DATA_W{1'b0}};
      par_r   <= 1'b0;
      stop_r  <= 1'b0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
      shift_r <= shift_s;
      par_r   <= par_s;
      stop_r  <= stop_s;
      done_r  <= done_s;
      busy_r  <= (state_s != S_IDLE);
    end
  end

  // Output stage: publish word and flags one cycle after the stop sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r  <= {DATA_W{1'b0}};
      valid_r <= 1'b0;
      perr_r  <= 1'b0;
      ferr_r  <= 1'b0;
    end else if (done_r) begin
      data_r  <= shift_r;
      valid_r <= 1'b1;
      perr_r  <= PAR_L ? parity_err_f(shift_r, par_r) : 1'b0;
      ferr_r  <= ~stop_r;
    end else begin
      valid_r <= 1'b0;
    end
  end

  assign data_o       = data_r;
  assign valid_o      = valid_r;
  assign parity_err_o = perr_r;
  assign frame_err_o  = ferr_r;
  assign busy_o       = busy_r;

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed bench for uart_rx_deser (BAUD_DIV=8, DATA_W=8, even parity).
module tb_uart_rx_deser;

  localparam int DW = 8;
  localparam int BD = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_i = 1'b1;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          parity_err_o;
  logic          frame_err_o;
  logic          busy_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int start_cyc = 0;
  int base_n;
  int c0;

  logic [DW-1:0] vdata_q[$];
  int            vcyc_q[$];
  logic          vperr_q[$];
  logic          vferr_q[$];

  uart_rx_deser #(.DATA_W(DW), .BAUD_DIV(BD), .PARITY_EN(1), .PARITY_ODD(0)) dut (
    .clk(clk), .rst(rst), .rx_i(rx_i), .data_o(data_o), .valid_o(valid_o),
    .parity_err_o(parity_err_o), .frame_err_o(frame_err_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every valid pulse with the posedge count at which it appeared.
  always @(negedge clk) begin
    if (valid_o === 1'b1) begin
      vdata_q.push_back(data_o);
      vcyc_q.push_back(cyc);
      vperr_q.push_back(parity_err_o);
      vferr_q.push_back(frame_err_o);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic stp);
    rx_i = 1'b0;
    start_cyc = cyc + 1;
    repeat (BD) tick();
    for (int i = 0; i < DW; i++) begin
      rx_i = d[i];
      repeat (BD) tick();
    end
    rx_i = p;
    repeat (BD) tick();
    rx_i = stp;
    repeat (BD) tick();
  endtask

  task automatic idle(input int n);
    rx_i = 1'b1;
    repeat (n) tick();
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_data", 32'(data_o), 32'h0);
    check("rst_valid", 32'(valid_o), 32'h0);
    check("rst_perr", 32'(parity_err_o), 32'h0);
    check("rst_ferr", 32'(frame_err_o), 32'h0);
    check("rst_busy", 32'(busy_o), 32'h0);
    rst = 1'b0;
    idle(10);

    // 1: 0xA5, even parity p=0, good stop; latency 8*10+4+1
    base_n = vdata_q.size();
    send_frame(8'hA5, 1'b0, 1'b1);
    idle(5);
    check("t1_pulses", 32'(vdata_q.size() - base_n), 32'd1);
    if (vdata_q.size() > base_n) begin
      check("t1_data", 32'(vdata_q[base_n]), 32'hA5);
      check("t1_perr", 32'(vperr_q[base_n]), 32'h0);
      check("t1_ferr", 32'(vferr_q[base_n]), 32'h0);
      check("t1_latency", 32'(vcyc_q[base_n] - start_cyc), 32'd85);
    end
    check("t1_busy_idle", 32'(busy_o), 32'h0);

    // 2: 0x3C with wrong parity bit p=1
    base_n = vdata_q.size();
    send_frame(8'h3C, 1'b1, 1'b1);
    idle(20);
    check("t2_pulses", 32'(vdata_q.size() - base_n), 32'd1);
    if (vdata_q.size() > base_n) begin
      check("t2_data", 32'(vdata_q[base_n]), 32'h3C);
      check("t2_perr", 32'(vperr_q[base_n]), 32'h1);
      check("t2_ferr", 32'(vferr_q[base_n]), 32'h0);
    end
    check("t2_perr_hold", 32'(parity_err_o), 32'h1);
    check("t2_data_hold", 32'(data_o), 32'h3C);
    check("t2_valid_low", 32'(valid_o), 32'h0);

    // 3: 0x81 with stop=0 (framing error), line then returns high
    base_n = vdata_q.size();
    send_frame(8'h81, 1'b0, 1'b0);
    idle(30);
    check("t3_pulses", 32'(vdata_q.size() - base_n), 32'd1);
    if (vdata_q.size() > base_n) begin
      check("t3_data", 32'(vdata_q[base_n]), 32'h81);
      check("t3_ferr", 32'(vferr_q[base_n]), 32'h1);
      check("t3_perr", 32'(vperr_q[base_n]), 32'h0);
    end
    check("t3_busy_idle", 32'(busy_o), 32'h0);

    // 4: 2-clk low glitch is rejected at mid-start
    base_n = vdata_q.size();
    rx_i = 1'b0;
    tick();
    check("t4_busy_start", 32'(busy_o), 32'h1);
    tick();
    rx_i = 1'b1;
    repeat (2) tick();
    check("t4_busy_before_mid", 32'(busy_o), 32'h1);
    tick();
    check("t4_busy_after_mid", 32'(busy_o), 32'h0);
    idle(100);
    check("t4_no_pulse", 32'(vdata_q.size() - base_n), 32'd0);
    check("t4_busy_idle", 32'(busy_o), 32'h0);

    // 5: back-to-back 0x55 then 0xAA, pulses one 11-bit frame apart
    base_n = vdata_q.size();
    send_frame(8'h55, 1'b0, 1'b1);
    send_frame(8'hAA, 1'b0, 1'b1);
    idle(10);
    check("t5_pulses", 32'(vdata_q.size() - base_n), 32'd2);
    if (vdata_q.size() >= base_n + 2) begin
      check("t5_data0", 32'(vdata_q[base_n]), 32'h55);
      check("t5_data1", 32'(vdata_q[base_n+1]), 32'hAA);
      check("t5_spacing", 32'(vcyc_q[base_n+1] - vcyc_q[base_n]), 32'(11 * BD));
      check("t5_perr1", 32'(vperr_q[base_n+1]), 32'h0);
      check("t5_ferr1", 32'(vferr_q[base_n+1]), 32'h0);
    end

    // 6: reset in the middle of data bit 4, then a clean 0x12
    base_n = vdata_q.size();
    rx_i = 1'b0;
    repeat (BD) tick();
    for (int i = 0; i < 4; i++) begin
      rx_i = c0[0];
      c0 = 8'h12 >> i;
      rx_i = c0[0];
      repeat (BD) tick();
    end
    rx_i = 1'b1;
    repeat (BD / 2) tick();
    check("t6_busy_pre_rst", 32'(busy_o), 32'h1);
    rst = 1'b1;
    tick();
    check("t6_rst_data", 32'(data_o), 32'h0);
    check("t6_rst_valid", 32'(valid_o), 32'h0);
    check("t6_rst_perr", 32'(parity_err_o), 32'h0);
    check("t6_rst_ferr", 32'(frame_err_o), 32'h0);
    check("t6_rst_busy", 32'(busy_o), 32'h0);
    rst = 1'b0;
    idle(100);
    check("t6_no_pulse", 32'(vdata_q.size() - base_n), 32'd0);
    send_frame(8'h12, 1'b0, 1'b1);
    idle(10);
    check("t6_pulses", 32'(vdata_q.size() - base_n), 32'd1);
    if (vdata_q.size() > base_n) begin
      check("t6_data", 32'(vdata_q[base_n]), 32'h12);
      check("t6_perr", 32'(vperr_q[base_n]), 32'h0);
      check("t6_ferr", 32'(vferr_q[base_n]), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
